// File: rtl/selector_casillas_core.sv
// Cursor and cell-selection core for the 3x3 "gato" board: edge-detected buttons, cell store, move strobes.
// Optional build macro CURSOR_WRAP_EN makes cursor moves wrap within the row/column instead of saturating.
module selector_casillas_core #(
    parameter int START_CELL = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boton_arriba,
    input  logic       boton_abajo,
    input  logic       boton_izq,
    input  logic       boton_der,
    input  logic       boton_elige,
    input  logic       turno_p1,
    input  logic       turno_p2,
    output logic [1:0] guarda_c1,
    output logic [1:0] guarda_c2,
    output logic [1:0] guarda_c3,
    output logic [1:0] guarda_c4,
    output logic [1:0] guarda_c5,
    output logic [1:0] guarda_c6,
    output logic [1:0] guarda_c7,
    output logic [1:0] guarda_c8,
    output logic [1:0] guarda_c9,
    output logic       p1_mm,
    output logic       p2_mm,
    output logic [3:0] cuadro,
    output logic [3:0] circulo,
    output logic [3:0] equis
);

    localparam logic [3:0] START_C = 4'(START_CELL);
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    // Column (0..2) of a zero-based cell index.
    function automatic logic [1:0] col_of(input logic [3:0] idx);
        logic [1:0] c;
        case (idx)
            4'd0, 4'd3, 4'd6: c = 2'd0;
            4'd1, 4'd4, 4'd7: c = 2'd1;
            default:          c = 2'd2;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] move_up(input logic [3:0] idx);
        logic [3:0] r;
        if (idx >= 4'd3) begin
            r = idx - 4'd3;
        end else begin
`ifdef CURSOR_WRAP_EN
            r = idx + 4'd6;
`else
            r = idx;
`endif
        end
        return r;
    endfunction

    function automatic logic [3:0] move_down(input logic [3:0] idx);
        logic [3:0] r;
        if (idx < 4'd6) begin
            r = idx + 4'd3;
        end else begin
`ifdef CURSOR_WRAP_EN
            r = idx - 4'd6;
`else
            r = idx;
`endif
        end
        return r;
    endfunction

    function automatic logic [3:0] move_left(input logic [3:0] idx);
        logic [3:0] r;
        if (col_of(idx) != 2'd0) begin
            r = idx - 4'd1;
        end else begin
`ifdef CURSOR_WRAP_EN
            r = idx + 4'd2;
`else
            r = idx;
`endif
        end
        return r;
    endfunction

    function automatic logic [3:0] move_right(input logic [3:0] idx);
        logic [3:0] r;
        if (col_of(idx) != 2'd2) begin
            r = idx + 4'd1;
        end else begin
`ifdef CURSOR_WRAP_EN
            r = idx - 4'd2;
`else
            r = idx;
`endif
        end
        return r;
    endfunction

    // Button vector order doubles as priority order: elige, arriba, abajo, izq, der.
    logic [4:0] btn_s;
    logic [4:0] btn_prev_r;
    logic [4:0] evt_s;
    logic [3:0] idx_s;
    logic [1:0] cells_r  [9];
    logic [1:0] cells_nx_s [9];
    logic [3:0] cuadro_r, cuadro_nx_s;
    logic [3:0] circulo_r, circulo_nx_s;
    logic [3:0] equis_r, equis_nx_s;
    logic       p1_mm_r, p1_mm_nx_s;
    logic       p2_mm_r, p2_mm_nx_s;

    assign btn_s = {boton_elige, boton_arriba, boton_abajo, boton_izq, boton_der};
    assign evt_s = btn_s & ~btn_prev_r;
    assign idx_s = cuadro_r - 4'd1;

    // Next-state: elige wins over every move; moves resolved in fixed priority.
    always_comb begin
        cells_nx_s   = cells_r;
        cuadro_nx_s  = cuadro_r;
        circulo_nx_s = circulo_r;
        equis_nx_s   = equis_r;
        p1_mm_nx_s   = 1'b0;
        p2_mm_nx_s   = 1'b0;
        if (evt_s[4]) begin
            if (cells_r[idx_s] == CELL_EMPTY && turno_p1 && !turno_p2) begin
                cells_nx_s[idx_s] = CELL_P1;
                circulo_nx_s      = cuadro_r;
                p1_mm_nx_s        = 1'b1;
            end else if (cells_r[idx_s] == CELL_EMPTY && turno_p2 && !turno_p1) begin
                cells_nx_s[idx_s] = CELL_P2;
                equis_nx_s        = cuadro_r;
                p2_mm_nx_s        = 1'b1;
            end else begin
                cells_nx_s[idx_s] = cells_r[idx_s];
            end
        end else if (evt_s[3]) begin
            cuadro_nx_s = move_up(idx_s) + 4'd1;
        end else if (evt_s[2]) begin
            cuadro_nx_s = move_down(idx_s) + 4'd1;
        end else if (evt_s[1]) begin
            cuadro_nx_s = move_left(idx_s) + 4'd1;
        end else if (evt_s[0]) begin
            cuadro_nx_s = move_right(idx_s) + 4'd1;
        end else begin
            cuadro_nx_s = cuadro_r;
        end
    end

    // State registers, including the button history used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_r <= 5'b00000;
            cuadro_r   <= START_C;
            circulo_r  <= 4'd0;
            equis_r    <= 4'd0;
            p1_mm_r    <= 1'b0;
            p2_mm_r    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                cells_r[i] <= CELL_EMPTY;
            end
        end else begin
            btn_prev_r <= btn_s;
            cuadro_r   <= cuadro_nx_s;
            circulo_r  <= circulo_nx_s;
            equis_r    <= equis_nx_s;
            p1_mm_r    <= p1_mm_nx_s;
            p2_mm_r    <= p2_mm_nx_s;
            cells_r    <= cells_nx_s;
        end
    end

    assign guarda_c1 = cells_r[0];
    assign guarda_c2 = cells_r[1];
    assign guarda_c3 = cells_r[2];
    assign guarda_c4 = cells_r[3];
    assign guarda_c5 = cells_r[4];
    assign guarda_c6 = cells_r[5];
    assign guarda_c7 = cells_r[6];
    assign guarda_c8 = cells_r[7];
    assign guarda_c9 = cells_r[8];
    assign p1_mm     = p1_mm_r;
    assign p2_mm     = p2_mm_r;
    assign cuadro    = cuadro_r;
    assign circulo   = circulo_r;
    assign equis     = equis_r;

endmodule

// File: tb/tb_selector_casillas_core.sv
// Scoreboard bench for selector_casillas_core: driver queues hand-computed expectations, monitor compares.
module tb_selector_casillas_core;

    typedef struct packed {
        logic [3:0]  cuadro;
        logic [3:0]  circulo;
        logic [3:0]  equis;
        logic [17:0] cells;
        logic        p1;
        logic        p2;
    } exp_t;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_EL   = 5'b10000;
    localparam logic [4:0] B_UP   = 5'b01000;
    localparam logic [4:0] B_DN   = 5'b00100;
    localparam logic [4:0] B_LF   = 5'b00010;
    localparam logic [4:0] B_RT   = 5'b00001;
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_P1   = 2'b10;
    localparam logic [1:0] T_P2   = 2'b01;
    localparam logic [1:0] T_BOTH = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic boton_arriba = 1'b0, boton_abajo = 1'b0, boton_izq = 1'b0, boton_der = 1'b0, boton_elige = 1'b0;
    logic turno_p1 = 1'b0, turno_p2 = 1'b0;
    logic [1:0] guarda_c1, guarda_c2, guarda_c3, guarda_c4, guarda_c5;
    logic [1:0] guarda_c6, guarda_c7, guarda_c8, guarda_c9;
    logic p1_mm, p2_mm;
    logic [3:0] cuadro, circulo, equis;

    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_circulo;
    logic [3:0]  exp_equis;
    logic [17:0] exp_cells;
    logic [17:0] dut_cells;

    assign dut_cells = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                        guarda_c4, guarda_c3, guarda_c2, guarda_c1};

    selector_casillas_core #(.START_CELL(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .boton_arriba(boton_arriba), .boton_abajo(boton_abajo),
        .boton_izq(boton_izq), .boton_der(boton_der), .boton_elige(boton_elige),
        .turno_p1(turno_p1), .turno_p2(turno_p2),
        .guarda_c1(guarda_c1), .guarda_c2(guarda_c2), .guarda_c3(guarda_c3),
        .guarda_c4(guarda_c4), .guarda_c5(guarda_c5), .guarda_c6(guarda_c6),
        .guarda_c7(guarda_c7), .guarda_c8(guarda_c8), .guarda_c9(guarda_c9),
        .p1_mm(p1_mm), .p2_mm(p2_mm),
        .cuadro(cuadro), .circulo(circulo), .equis(equis)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are registered, so each queued expectation is checked on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (cuadro !== mon_e.cuadro) begin
                errors++;
                $display("FAIL cuadro: got %0d expected %0d at %0t", cuadro, mon_e.cuadro, $time);
            end
            checks++;
            if (circulo !== mon_e.circulo) begin
                errors++;
                $display("FAIL circulo: got %0d expected %0d at %0t", circulo, mon_e.circulo, $time);
            end
            checks++;
            if (equis !== mon_e.equis) begin
                errors++;
                $display("FAIL equis: got %0d expected %0d at %0t", equis, mon_e.equis, $time);
            end
            checks++;
            if (dut_cells !== mon_e.cells) begin
                errors++;
                $display("FAIL cells: got %b expected %b at %0t", dut_cells, mon_e.cells, $time);
            end
            checks++;
            if ({p1_mm, p2_mm} !== {mon_e.p1, mon_e.p2}) begin
                errors++;
                $display("FAIL strobes: got p1=%b p2=%b expected p1=%b p2=%b at %0t",
                         p1_mm, p2_mm, mon_e.p1, mon_e.p2, $time);
            end
        end
    end

    task automatic push_exp(input logic [3:0] ec, input logic s1, input logic s2);
        exp_t e;
        e.cuadro  = ec;
        e.circulo = exp_circulo;
        e.equis   = exp_equis;
        e.cells   = exp_cells;
        e.p1      = s1;
        e.p2      = s2;
        sb_q.push_back(e);
    endtask

    // One clock of stimulus; expectation describes outputs after that rising edge.
    task automatic step(input logic [4:0] b, input logic [1:0] t,
                        input logic [3:0] ec, input logic s1, input logic s2);
        {boton_elige, boton_arriba, boton_abajo, boton_izq, boton_der} = b;
        {turno_p1, turno_p2} = t;
        @(posedge clk);
        #1;
        push_exp(ec, s1, s2);
        @(negedge clk);
    endtask

    task automatic set_cell(input int n, input logic [1:0] v);
        exp_cells[2*(n-1) +: 2] = v;
    endtask

    task automatic clear_exp();
        exp_circulo = 4'd0;
        exp_equis   = 4'd0;
        exp_cells   = 18'd0;
    endtask

    initial begin
        clear_exp();
        // Reset and idle
        @(negedge clk);
        @(posedge clk); #1; push_exp(4'd5, 1'b0, 1'b0); @(negedge clk);
        rst_n = 1'b1;
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);

        // Up move, repeat at top edge, held abajo
        step(B_UP,   T_NONE, 4'd2, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd2, 1'b0, 1'b0);
`ifdef CURSOR_WRAP_EN
        step(B_UP,   T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_DN,   T_NONE, 4'd2, 1'b0, 1'b0);
`else
        step(B_UP,   T_NONE, 4'd2, 1'b0, 1'b0);
`endif
        step(B_NONE, T_NONE, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(B_DN, T_NONE, 4'd5, 1'b0, 1'b0);
        end
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);

        // Corner moves
        step(B_LF,   T_NONE, 4'd4, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd4, 1'b0, 1'b0);
        step(B_DN,   T_NONE, 4'd7, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd7, 1'b0, 1'b0);
        step(B_RT,   T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_RT,   T_NONE, 4'd9, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd9, 1'b0, 1'b0);
`ifdef CURSOR_WRAP_EN
        step(B_RT,   T_NONE, 4'd7, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd7, 1'b0, 1'b0);
        step(B_LF,   T_NONE, 4'd9, 1'b0, 1'b0);
`else
        step(B_RT,   T_NONE, 4'd9, 1'b0, 1'b0);
`endif
        step(B_NONE, T_NONE, 4'd9, 1'b0, 1'b0);
        step(B_UP,   T_NONE, 4'd6, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd6, 1'b0, 1'b0);
        step(B_LF,   T_NONE, 4'd5, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);

        // Player 1 marks centre; held elige gives a single strobe
        set_cell(5, 2'b01); exp_circulo = 4'd5;
        step(B_EL,   T_P1,   4'd5, 1'b1, 1'b0);
        step(B_EL,   T_P1,   4'd5, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);

        // Occupied cell rejected, then player 2 marks cell 2
        step(B_EL,   T_P2,   4'd5, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);
        step(B_UP,   T_NONE, 4'd2, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd2, 1'b0, 1'b0);
        set_cell(2, 2'b10); exp_equis = 4'd2;
        step(B_EL,   T_P2,   4'd2, 1'b0, 1'b1);
        step(B_NONE, T_NONE, 4'd2, 1'b0, 1'b0);

        // Invalid turn combinations at empty cell 8
        step(B_DN,   T_NONE, 4'd5, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);
        step(B_DN,   T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_EL,   T_BOTH, 4'd8, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_EL,   T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd8, 1'b0, 1'b0);

        // Priority: elige over arriba, then direction pairs
        set_cell(8, 2'b01); exp_circulo = 4'd8;
        step(B_EL | B_UP, T_P1, 4'd8, 1'b1, 1'b0);
        step(B_NONE, T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_UP | B_RT, T_NONE, 4'd5, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);
        step(B_DN | B_LF, T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd8, 1'b0, 1'b0);
        step(B_LF | B_RT, T_NONE, 4'd7, 1'b0, 1'b0);
        step(B_NONE, T_NONE, 4'd7, 1'b0, 1'b0);

        // Reset asserted while a strobe is high clears everything
        set_cell(7, 2'b10); exp_equis = 4'd7;
        step(B_EL,   T_P2,   4'd7, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        clear_exp();
        @(posedge clk); #1; push_exp(4'd5, 1'b0, 1'b0); @(negedge clk);
        {boton_elige, boton_arriba, boton_abajo, boton_izq, boton_der} = B_NONE;
        rst_n = 1'b1;
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);
        set_cell(5, 2'b01); exp_circulo = 4'd5;
        step(B_EL,   T_P1,   4'd5, 1'b1, 1'b0);
        step(B_NONE, T_NONE, 4'd5, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
